// File: rtl/sdnet_to_mtpsa.sv
// Re-attaches SDNet metadata tuples to the first beat of each output packet
// as AXI-Stream tuser; the tuple FIFO gates first beats until a tuple exists.
module sdnet_to_mtpsa #(
  parameter int TUPLE_WIDTH    = 128,
  parameter int FIFO_ADDR_BITS = 2
) (
  input  logic                      axis_aclk,
  input  logic                      axis_resetn,
  input  logic                      SDNet_tuple_VALID,
  input  logic [TUPLE_WIDTH-1:0]    SDNet_tuple_DATA,
  input  logic                      SDNet_axis_TVALID,
  input  logic                      SDNet_axis_TLAST,
  output logic                      SDNet_axis_TREADY,
  output logic                      m_axis_tvalid,
  output logic                      m_axis_tlast,
  output logic [TUPLE_WIDTH-1:0]    m_axis_tuser,
  input  logic                      m_axis_tready,
  output logic                      tuple_overflow,
  output logic [FIFO_ADDR_BITS:0]   fifo_level,
  output logic [31:0]               pkt_count
);

  localparam int DEPTH = 1 << FIFO_ADDR_BITS;
  localparam logic [0:0] S_FIRST = 1'b0;
  localparam logic [0:0] S_BODY  = 1'b1;

  logic [TUPLE_WIDTH-1:0]    mem_q [DEPTH];
  logic [FIFO_ADDR_BITS-1:0] wr_ptr_q, rd_ptr_q;
  logic [FIFO_ADDR_BITS:0]   level_q, level_d;
  logic [0:0]                state_q, state_d;
  logic [31:0]               pkt_q;
  logic                      ovf_q;

  logic empty, full, hs, pop, push, drop;

  assign empty = (level_q == '0);
  assign full  = (level_q == (FIFO_ADDR_BITS+1)'(DEPTH));

  always_comb begin
    m_axis_tvalid     = 1'b0;
    m_axis_tuser      = '0;
    SDNet_axis_TREADY = 1'b0;
    case (state_q)
      S_FIRST: begin
        m_axis_tvalid     = SDNet_axis_TVALID & ~empty;
        SDNet_axis_TREADY = m_axis_tready & ~empty;
        if (m_axis_tvalid) m_axis_tuser = mem_q[rd_ptr_q];
      end
      default: begin
        m_axis_tvalid     = SDNet_axis_TVALID;
        SDNet_axis_TREADY = m_axis_tready;
      end
    endcase
  end

  assign m_axis_tlast = SDNet_axis_TLAST & m_axis_tvalid;

  assign hs   = m_axis_tvalid & m_axis_tready;
  assign pop  = hs & (state_q == S_FIRST);
  // A pop in the same cycle frees the slot, so a full FIFO still accepts.
  assign push = SDNet_tuple_VALID & (~full | pop);
  assign drop = SDNet_tuple_VALID & full & ~pop;

  always_comb begin
    level_d = level_q;
    case ({push, pop})
      2'b10:   level_d = level_q + (FIFO_ADDR_BITS+1)'(1);
      2'b01:   level_d = level_q - (FIFO_ADDR_BITS+1)'(1);
      default: level_d = level_q;
    endcase
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FIRST: if (pop && !SDNet_axis_TLAST) state_d = S_BODY;
      default: if (hs && SDNet_axis_TLAST)   state_d = S_FIRST;
    endcase
  end

  always_ff @(posedge axis_aclk) begin
    if (push) mem_q[wr_ptr_q] <= SDNet_tuple_DATA;
  end

  always_ff @(posedge axis_aclk or negedge axis_resetn) begin
    if (!axis_resetn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      state_q  <= S_FIRST;
      pkt_q    <= '0;
      ovf_q    <= 1'b0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      level_q <= level_d;
      state_q <= state_d;
      if (hs && SDNet_axis_TLAST) pkt_q <= pkt_q + 32'd1;
      if (drop) ovf_q <= 1'b1;
    end
  end

  assign fifo_level     = level_q;
  assign pkt_count      = pkt_q;
  assign tuple_overflow = ovf_q;

endmodule

// File: tb/tb_sdnet_to_mtpsa.sv
// Scoreboard bench for sdnet_to_mtpsa: directed packets push expected
// first-beat tuser/tlast, a negedge monitor compares every handshake.
module tb_sdnet_to_mtpsa;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         t_valid;
  logic [127:0] t_data;
  logic         s_tvalid;
  logic         s_tlast;
  logic         s_tready;
  logic         m_tvalid;
  logic         m_tlast;
  logic [127:0] m_tuser;
  logic         m_tready;
  logic         ovf;
  logic [2:0]   level;
  logic [31:0]  pkts;

  typedef struct packed {
    logic [127:0] tuser;
    logic         tlast;
  } beat_t;

  beat_t exp_q[$];
  int total = 0;
  int passed = 0;

  sdnet_to_mtpsa dut (
    .axis_aclk         (clk),
    .axis_resetn       (rst_n),
    .SDNet_tuple_VALID (t_valid),
    .SDNet_tuple_DATA  (t_data),
    .SDNet_axis_TVALID (s_tvalid),
    .SDNet_axis_TLAST  (s_tlast),
    .SDNet_axis_TREADY (s_tready),
    .m_axis_tvalid     (m_tvalid),
    .m_axis_tlast      (m_tlast),
    .m_axis_tuser      (m_tuser),
    .m_axis_tready     (m_tready),
    .tuple_overflow    (ovf),
    .fifo_level        (level),
    .pkt_count         (pkts)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [127:0] act,
                     input logic [127:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  always @(negedge clk) begin
    if (rst_n && m_tvalid && m_tready) begin
      if (exp_q.size() == 0) begin
        total++;
        $display("FAIL monitor: unexpected beat tuser %0h", m_tuser);
      end else begin
        beat_t e;
        e = exp_q.pop_front();
        chk("mon_tuser", m_tuser, e.tuser);
        chk("mon_tlast", {127'd0, m_tlast}, {127'd0, e.tlast});
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_tuple(input logic [127:0] v);
    t_valid = 1'b1;
    t_data  = v;
    tick();
    t_valid = 1'b0;
  endtask

  task automatic beat(input logic last);
    int k;
    s_tvalid = 1'b1;
    s_tlast  = last;
    for (k = 0; k < 50; k++) begin
      @(negedge clk);
      if (s_tready && m_tvalid) break;
    end
    if (k == 50) begin
      total++;
      $display("FAIL beat_timeout: got stall expected handshake");
    end
    tick();
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
  endtask

  task automatic send_pkt(input logic [127:0] tu, input int n);
    for (int i = 0; i < n; i++) begin
      beat_t e;
      e.tuser = (i == 0) ? tu : 128'd0;
      e.tlast = (i == n - 1);
      exp_q.push_back(e);
    end
    for (int i = 0; i < n; i++) beat(i == n - 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    t_valid = 1'b0;
    t_data = '0;
    s_tvalid = 1'b0;
    s_tlast = 1'b0;
    m_tready = 1'b1;
    #22;
    chk("rst_tvalid", {127'd0, m_tvalid}, 0);
    chk("rst_tready", {127'd0, s_tready}, 0);
    chk("rst_tuser", m_tuser, 0);
    chk("rst_level", {125'd0, level}, 0);
    chk("rst_pkts", {96'd0, pkts}, 0);
    chk("rst_ovf", {127'd0, ovf}, 0);
    rst_n = 1'b1;
    tick();

    // single 3-beat packet, tuple first
    push_tuple(128'hA5);
    chk("t1_level1", {125'd0, level}, 1);
    tick();
    send_pkt(128'hA5, 3);
    chk("t1_pkts", {96'd0, pkts}, 1);
    chk("t1_level0", {125'd0, level}, 0);

    // packet before tuple: stall, no same-cycle bypass
    exp_q.push_back('{tuser: 128'h11, tlast: 1'b1});
    s_tvalid = 1'b1;
    s_tlast = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("t2_stall_valid", {127'd0, m_tvalid}, 0);
      chk("t2_stall_ready", {127'd0, s_tready}, 0);
      tick();
    end
    t_valid = 1'b1;
    t_data = 128'h11;
    @(negedge clk);
    chk("t2_nobypass", {127'd0, m_tvalid}, 0);
    tick();
    t_valid = 1'b0;
    @(negedge clk);
    chk("t2_go_valid", {127'd0, m_tvalid}, 1);
    tick();
    s_tvalid = 1'b0;
    s_tlast = 1'b0;
    chk("t2_pkts", {96'd0, pkts}, 2);

    // full FIFO with simultaneous push and pop
    for (int i = 1; i <= 4; i++) push_tuple(128'(i));
    chk("t3_full", {125'd0, level}, 4);
    exp_q.push_back('{tuser: 128'h1, tlast: 1'b1});
    s_tvalid = 1'b1;
    s_tlast = 1'b1;
    t_valid = 1'b1;
    t_data = 128'h99;
    tick();
    s_tvalid = 1'b0;
    s_tlast = 1'b0;
    t_valid = 1'b0;
    chk("t3_level", {125'd0, level}, 4);
    chk("t3_ovf", {127'd0, ovf}, 0);
    send_pkt(128'h2, 1);
    send_pkt(128'h3, 1);
    send_pkt(128'h4, 1);
    send_pkt(128'h99, 1);
    chk("t3_drained", {125'd0, level}, 0);

    // overflow
    for (int i = 1; i <= 5; i++) push_tuple(128'(i));
    chk("t4_level", {125'd0, level}, 4);
    chk("t4_ovf", {127'd0, ovf}, 1);
    for (int i = 1; i <= 4; i++) send_pkt(128'(i), 1);
    chk("t4_level0", {125'd0, level}, 0);
    chk("t4_sticky", {127'd0, ovf}, 1);

    // back-pressure on the first beat
    push_tuple(128'h77);
    push_tuple(128'h55);
    exp_q.push_back('{tuser: 128'h77, tlast: 1'b0});
    exp_q.push_back('{tuser: 128'h0, tlast: 1'b1});
    m_tready = 1'b0;
    s_tvalid = 1'b1;
    s_tlast = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("t5_hold_valid", {127'd0, m_tvalid}, 1);
      chk("t5_hold_tuser", m_tuser, 128'h77);
      chk("t5_tready_lo", {127'd0, s_tready}, 0);
      tick();
    end
    chk("t5_nopop", {125'd0, level}, 2);
    m_tready = 1'b1;
    @(negedge clk);
    chk("t5_tready_hi", {127'd0, s_tready}, 1);
    tick();
    chk("t5_onepop", {125'd0, level}, 1);
    beat(1'b1);
    chk("t5_pkts", {96'd0, pkts}, 12);

    // reset mid-packet with 2 tuples buffered
    push_tuple(128'hB1);
    push_tuple(128'hB2);
    exp_q.push_back('{tuser: 128'h55, tlast: 1'b0});
    s_tvalid = 1'b1;
    s_tlast = 1'b0;
    @(negedge clk);
    tick();
    chk("t6_body_level", {125'd0, level}, 2);
    chk("t6_body_valid", {127'd0, m_tvalid}, 1);
    rst_n = 1'b0;
    #1;
    chk("t6_rst_valid", {127'd0, m_tvalid}, 0);
    chk("t6_rst_tready", {127'd0, s_tready}, 0);
    chk("t6_rst_tuser", m_tuser, 0);
    chk("t6_rst_level", {125'd0, level}, 0);
    chk("t6_rst_pkts", {96'd0, pkts}, 0);
    #10;
    rst_n = 1'b1;
    s_tlast = 1'b1;
    tick();
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk("t6_stall", {127'd0, m_tvalid}, 0);
      tick();
    end
    push_tuple(128'hC3);
    exp_q.push_back('{tuser: 128'hC3, tlast: 1'b1});
    beat(1'b1);
    chk("t6_pkts", {96'd0, pkts}, 1);
    chk("t6_ovf", {127'd0, ovf}, 0);

    tick();
    chk("sb_empty", 128'(exp_q.size()), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/sdnet_to_mtpsa.md
# sdnet_to_mtpsa

Downstream companion of the SUME-to-SDNet control shim. It collects the metadata tuples emitted by the SDNet pipeline in a small FIFO. Each tuple is re-attached to the first beat of the matching output packet as AXI-Stream `tuser`, so the MTPSA output queues see SUME-style streams again. Packet data travels on a separate datapath; this block owns only valid, last and ready gating, the `tuser` merge and its statistics.

## Interface
- `TUPLE_WIDTH`, 128, width of the SDNet output metadata tuple and of `m_axis_tuser`
- `FIFO_ADDR_BITS`, 2, tuple FIFO depth is 2^FIFO_ADDR_BITS (default 4 entries)
- `axis_aclk`  in  1  single clock for all logic
- `axis_resetn`  in  1  reset, asynchronous, active-low
- `SDNet_tuple_VALID`  in  1  one-cycle pulse, tuple present on `SDNet_tuple_DATA`
- `SDNet_tuple_DATA`  in  TUPLE_WIDTH  metadata tuple from SDNet
- `SDNet_axis_TVALID`  in  1  SDNet packet beat valid
- `SDNet_axis_TLAST`  in  1  SDNet packet last beat
- `SDNet_axis_TREADY`  out  1  back-pressure to SDNet packet output
- `m_axis_tvalid`  out  1  beat valid toward MTPSA
- `m_axis_tlast`  out  1  last beat toward MTPSA
- `m_axis_tuser`  out  TUPLE_WIDTH  tuple on first beat, zero on all other beats
- `m_axis_tready`  in  1  downstream ready
- `tuple_overflow`  out  1  sticky, a tuple was dropped because the FIFO was full
- `fifo_level`  out  FIFO_ADDR_BITS+1  tuples currently stored
- `pkt_count`  out  32  packets completed (wraps 2^32-1 -> 0)

## Operation
- **Tuple FIFO**
  - Push when `SDNet_tuple_VALID` and (not full, or a pop happens in the same cycle).
  - Push while full with no pop: the tuple is dropped, `tuple_overflow` is set, and the FIFO is unchanged.
  - Pointers wrap modulo depth. `fifo_level` tracks pushes minus pops and is never greater than the depth.
- **State machine**, 2 states:
  - FIRST: the next beat is the first beat of a packet.
    - If `SDNet_axis_TVALID` and the FIFO is non-empty: `m_axis_tvalid`=1, `m_axis_tuser`=FIFO head, `SDNet_axis_TREADY`=`m_axis_tready`.
    - If the FIFO is empty: `m_axis_tvalid`=0 and `SDNet_axis_TREADY`=0 (stall until a tuple arrives).
    - Handshake (`m_axis_tvalid` & `m_axis_tready`): pop the FIFO. Go to BODY if `SDNet_axis_TLAST`=0; stay in FIRST and increment `pkt_count` if `SDNet_axis_TLAST`=1 (single-beat packet).
  - BODY: pure pass-through.
    - `m_axis_tvalid`=`SDNet_axis_TVALID`, `SDNet_axis_TREADY`=`m_axis_tready`, `m_axis_tuser`=0.
    - Handshake with `SDNet_axis_TLAST`=1: go to FIRST and increment `pkt_count`.
- `m_axis_tlast` = `SDNet_axis_TLAST` & `m_axis_tvalid`. It is never high without valid.
- `tuple_overflow` is cleared only by reset.

## Timing
- **Reset values:**
  - State FIRST, FIFO empty, `fifo_level`=0, `pkt_count`=0, `tuple_overflow`=0.
  - Hence `m_axis_tvalid`=0, `m_axis_tlast`=0, `m_axis_tuser`=0, `SDNet_axis_TREADY`=0.
- Reset asserted mid-packet: all state clears immediately, buffered tuples are discarded, and outputs take their reset values within the same cycle.
- **Data path:** combinational, zero latency from `SDNet_axis_*` and `m_axis_tready` to the outputs. No registers are added on the data path.
- **Tuple-to-use latency:** 1 cycle. A tuple written at edge N can qualify a first beat in the cycle after edge N. There is no same-cycle bypass into an empty FIFO.
- **Simultaneous push and pop:**
  - Level is unchanged.
  - When full, the push is accepted and no overflow is flagged.
  - When level is 1, the old head goes out and the new tuple becomes head.
- While the state is FIRST and `m_axis_tready`=0, `m_axis_tvalid` and `m_axis_tuser` hold stable until the handshake completes (AXI-Stream rule).
- `pkt_count` and `fifo_level` are registered and update on the edge after the event.

## Test plan
- **Single 3-beat packet, tuple first:**
  - Stimulus: tuple 0xA5 pulse in cycle 0; beats in cycles 2-4; `m_axis_tready`=1.
  - Required: `m_axis_tuser`=0xA5 on the first beat only, 0 on beats 2-3; `tlast` on beat 3; `pkt_count`=1; `fifo_level` 1 -> 0.
- **Packet before tuple:**
  - Stimulus: beat valid from cycle 0; tuple 0x11 pulsed in cycle 3.
  - Required: `m_axis_tvalid`=0 and `SDNet_axis_TREADY`=0 in cycles 0-3; first beat transfers in cycle 4 with `tuser`=0x11.
- **Overflow:**
  - Stimulus: 5 tuple pulses (1..5), no packets, depth 4.
  - Required: `fifo_level`=4, `tuple_overflow`=1. The next 4 single-beat packets carry `tuser` 1,2,3,4 in order.
- **Full with simultaneous push and pop:**
  - Stimulus: FIFO full; a first-beat handshake and a tuple pulse in the same cycle.
  - Required: `fifo_level` stays 4, `tuple_overflow` stays 0, new tuple is at the tail.
- **Back-pressure:**
  - Stimulus: `m_axis_tready`=0 for 3 cycles during the first beat, then 1.
  - Required: `tvalid` and `tuser` stable throughout, exactly one pop, `SDNet_axis_TREADY` mirrors `m_axis_tready`.
- **Reset mid-packet:**
  - Stimulus: assert `axis_resetn`=0 during BODY with 2 tuples buffered.
  - Required: outputs drop to reset values asynchronously; after release, `fifo_level`=0, `pkt_count`=0, and the next first beat stalls until a new tuple arrives.
